// File: rtl/mem_resp.sv
// Word-addressed 32-bit RAM with a registered read port and a power-up clear sequence.
// Accesses are honoured only after every word has been zeroed; misaligned or out-of-range addresses are rejected.
module mem_resp #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_cs,
  input  logic        ram_we,
  input  logic        ram_oe,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  // Legal means word aligned and no address bits above the word index; nothing aliases back to word 0.
  function automatic logic f_addr_legal(input logic [31:0] a);
    logic [31:0] hi_bits;
    hi_bits = a >> (IDX_W + 2);
    return (a[1:0] == 2'b00) && (hi_bits == 32'd0);
  endfunction

  logic [31:0]      r_mem [DEPTH_WORDS];
  state_t           r_state;
  logic [IDX_W-1:0] r_clr_cnt;
  logic [31:0]      r_rdata;
  logic             r_ready;
  logic             r_err;

  logic             w_legal;
  logic [IDX_W-1:0] w_idx;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic [31:0]      w_mem_wdata;
  logic             w_rd_en;
  logic             w_reject;

  // Decode the request and select the single RAM write port between clearing and user writes.
  always_comb begin
    w_legal     = f_addr_legal(addr);
    w_idx       = addr[IDX_W+1:2];
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_wdata = wdata;
    w_rd_en     = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_mem_we    = ~rst;
        w_mem_idx   = r_clr_cnt;
        w_mem_wdata = 32'h0000_0000;
      end
      S_RUN: begin
        if (ram_cs && (ram_we || ram_oe)) begin
          if (w_legal) begin
            // we has priority: cs+we+oe is a pure write
            w_mem_we = ram_we & ~rst;
            w_rd_en  = ~ram_we;
          end else begin
            w_reject = 1'b1;
          end
        end else begin
          w_mem_we = 1'b0;
        end
      end
      default: begin
        w_mem_we = 1'b0;
      end
    endcase
  end

  // Storage array; contents are zeroed by the clear sequence rather than by reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  // Control FSM with registered read data, ready and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= {IDX_W{1'b0}};
      r_rdata   <= 32'h0000_0000;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_err <= 1'b0;
          if (r_clr_cnt == LAST_IDX) begin
            r_state   <= S_RUN;
            r_ready   <= 1'b1;
            r_clr_cnt <= {IDX_W{1'b0}};
          end else begin
            r_ready   <= 1'b0;
            r_clr_cnt <= r_clr_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
        S_RUN: begin
          r_ready <= 1'b1;
          r_err   <= w_reject;
          if (w_rd_en) begin
            r_rdata <= r_mem[w_idx];
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_cnt <= {IDX_W{1'b0}};
          r_ready   <= 1'b0;
          r_err     <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;

endmodule

// File: tb/tb_mem_resp.sv
// Scoreboard bench for mem_resp: directed accesses push hand-computed expectations,
// a negedge monitor pops and compares rdata/err in the cycle each access takes effect.
module tb_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_cs = 1'b0;
  logic        ram_we = 1'b0;
  logic        ram_oe = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
    string       nm;
  } exp_t;

  exp_t sb_q[$];

  mem_resp #(.DEPTH_WORDS(256), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: compare every expectation due in the cycle just completed.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.due < cyc) begin
        chk({e.nm, "_stale"}, 32'(e.due), 32'(cyc));
      end else begin
        chk({e.nm, "_rdata"}, rdata, e.rd);
        chk({e.nm, "_err"}, {31'd0, err}, {31'd0, e.er});
      end
    end
  end

  // Issue one access for one clock and queue its expected outcome.
  task automatic acc(input logic cs, input logic we, input logic oe, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er,
                     input string nm);
    exp_t e;
    ram_cs = cs; ram_we = we; ram_oe = oe; addr = a; wdata = d;
    e.due = cyc + 1; e.rd = exp_rd; e.er = exp_er; e.nm = nm;
    sb_q.push_back(e);
    @(posedge clk); #1;
    ram_cs = 1'b0; ram_we = 1'b0; ram_oe = 1'b0;
  endtask

  // Release reset and count edges until ready, driving ignored traffic meanwhile.
  task automatic release_and_count(input string nm);
    int   n;
    logic bad;
    n = 0; bad = 1'b0;
    rst = 1'b0;
    ram_cs = 1'b1; ram_we = 1'b1; ram_oe = 1'b1; addr = 32'h10; wdata = 32'h1111_1111;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      addr = (i % 2 == 0) ? 32'h10 : 32'h402;
      if (err !== 1'b0 || rdata !== 32'd0) bad = 1'b1;
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
    ram_cs = 1'b0; ram_we = 1'b0; ram_oe = 1'b0;
    chk({nm, "_ready_cycles"}, 32'(n), 32'd256);
    chk({nm, "_clear_quiet"}, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);

    release_and_count("clr1");

    acc(1'b1, 1'b0, 1'b1, 32'h0,   32'd0, 32'h0, 1'b0, "rd0_cleared");
    acc(1'b1, 1'b0, 1'b1, 32'h10,  32'd0, 32'h0, 1'b0, "rd10_clear_ignored");
    acc(1'b1, 1'b0, 1'b1, 32'h3FC, 32'd0, 32'h0, 1'b0, "rd3fc_cleared");
    acc(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "wr10");
    acc(1'b1, 1'b0, 1'b1, 32'h10,  32'd0, 32'hDEAD_BEEF, 1'b0, "rd10");
    acc(1'b1, 1'b0, 1'b1, 32'h4,   32'd0, 32'h0, 1'b0, "b2b_rd4");
    acc(1'b1, 1'b0, 1'b1, 32'h10,  32'd0, 32'hDEAD_BEEF, 1'b0, "b2b_rd10");
    acc(1'b1, 1'b1, 1'b1, 32'h3FC, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, "wr_oe_3fc");
    acc(1'b1, 1'b0, 1'b1, 32'h3FC, 32'd0, 32'h1234_5678, 1'b0, "rd3fc");
    acc(1'b1, 1'b0, 1'b1, 32'h400, 32'd0, 32'h1234_5678, 1'b1, "rd400_rej");
    acc(1'b0, 1'b0, 1'b0, 32'h0,   32'd0, 32'h1234_5678, 1'b0, "err_one_cycle");
    acc(1'b1, 1'b0, 1'b1, 32'h2,   32'd0, 32'h1234_5678, 1'b1, "rd002_rej");
    acc(1'b1, 1'b1, 1'b0, 32'h400, 32'hBAD0_BAD0, 32'h1234_5678, 1'b1, "wr400_rej");
    acc(1'b1, 1'b0, 1'b1, 32'h8000_0010, 32'd0, 32'h1234_5678, 1'b1, "rd_hi_rej");
    acc(1'b1, 1'b0, 1'b1, 32'h0,   32'd0, 32'h0, 1'b0, "rd0_no_alias");
    acc(1'b0, 1'b1, 1'b0, 32'h8, 32'hFFFF_FFFF, 32'h0, 1'b0, "cs0_wr8");
    acc(1'b1, 1'b0, 1'b1, 32'h8,   32'd0, 32'h0, 1'b0, "rd8");
    acc(1'b1, 1'b0, 1'b0, 32'h10,  32'd0, 32'h0, 1'b0, "cs_noop");
    acc(1'b1, 1'b1, 1'b0, 32'h20, 32'hA5A5_A5A5, 32'h0, 1'b0, "wr20");
    acc(1'b1, 1'b0, 1'b1, 32'h20,  32'd0, 32'hA5A5_A5A5, 1'b0, "rd20");
    @(posedge clk); #1;

    rst = 1'b1; #1;
    chk("rst2_rdata", rdata, 32'd0);
    chk("rst2_ready", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("midclr_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst3_rdata", rdata, 32'd0);
    release_and_count("clr3");

    acc(1'b1, 1'b0, 1'b1, 32'h20, 32'd0, 32'h0, 1'b0, "rd20_after_rst");
    acc(1'b1, 1'b0, 1'b1, 32'h10, 32'd0, 32'h0, 1'b0, "rd10_after_rst");
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
